// File: rtl/dsm_pkg.sv
// ---------------------------------------------------------------------------
// dsm_pkg
// Shared constants, types and helpers for the interpolating delta-sigma DAC
// path (dsm_interp_modulator and its modulator core dsm_mod2).
//   IN_W      : host sample width (two's complement)
//   OSR_LOG2  : log2 of the interpolation ratio / tick period
//   ACC_W     : modulator integrator width (saturating)
//   CIC_W     : CIC datapath width, wide enough for the R^(N-1) = 64 gain
//   FS        : modulator full-scale feedback magnitude
// ---------------------------------------------------------------------------
package dsm_pkg;

   localparam int IN_W     = 16;
   localparam int OSR_LOG2 = 6;
   localparam int ACC_W    = 20;
   localparam int CIC_W    = IN_W + OSR_LOG2;
   localparam int FS       = 2 ** (IN_W - 1);

   typedef logic signed [IN_W-1:0]  sample_t;
   typedef logic signed [ACC_W-1:0] acc_t;
   typedef logic signed [CIC_W-1:0] cic_t;

   // Two guard bits: an integrator value plus two FS-sized terms never
   // overflows before it is clamped.
   typedef logic signed [ACC_W+1:0] acc_wide_t;

   localparam int        ACC_LIM   = (2 ** (ACC_W - 1)) - 1;
   localparam acc_t      ACC_POS   = acc_t'(ACC_LIM);
   localparam acc_t      ACC_NEG   = acc_t'(-ACC_LIM);
   localparam acc_wide_t ACC_POS_W = acc_wide_t'(ACC_LIM);
   localparam acc_wide_t ACC_NEG_W = acc_wide_t'(-ACC_LIM);

   // Clamp a guarded sum into the symmetric integrator range; the
   // integrators must never wrap, or the loop would lose its sign and
   // become unstable.
   function automatic acc_t sat_acc(input acc_wide_t v);
      if (v > ACC_POS_W) begin
         return ACC_POS;
      end else if (v < ACC_NEG_W) begin
         return ACC_NEG;
      end else begin
         return v[ACC_W-1:0];
      end
   endfunction

endpackage

// File: rtl/dsm_mod2.sv
// ---------------------------------------------------------------------------
// dsm_mod2
// Second-order CIFB delta-sigma modulator with a 1-bit quantiser.
// The decision v is taken from the sign of the second integrator; both
// integrators subtract the +/-FS feedback and saturate symmetrically.
// The second integrator accumulates the freshly updated first integrator,
// which gives the classic (1 - z^-1)^2 noise transfer function.
// Ports:
//   clk   in   bitstream-rate clock
//   rst   in   asynchronous active-high reset
//   i_u   in   interpolated sample (two's complement, FS = 2^15)
//   o_bit out  registered decision, 1 = +FS, 0 = -FS
// ---------------------------------------------------------------------------
module dsm_mod2
   import dsm_pkg::*;
(
   input  logic    clk,
   input  logic    rst,
   input  sample_t i_u,
   output logic    o_bit
);

   acc_t      r_s1;
   acc_t      r_s2;
   logic      r_bit;

   logic      w_v;
   acc_wide_t w_fb;
   acc_wide_t w_s1_sum;
   acc_wide_t w_s2_sum;
   acc_t      w_s1_next;
   acc_t      w_s2_next;

   // s2 >= 0 (sign bit clear) selects the positive feedback level.
   assign w_v       = ~r_s2[ACC_W-1];
   assign w_fb      = w_v ? acc_wide_t'(FS) : -acc_wide_t'(FS);

   assign w_s1_sum  = acc_wide_t'(r_s1) + acc_wide_t'(i_u) - w_fb;
   assign w_s1_next = sat_acc(w_s1_sum);

   assign w_s2_sum  = acc_wide_t'(r_s2) + acc_wide_t'(w_s1_next) - w_fb;
   assign w_s2_next = sat_acc(w_s2_sum);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1  <= '0;
         r_s2  <= '0;
         r_bit <= 1'b0;
      end else begin
         r_s1  <= w_s1_next;
         r_s2  <= w_s2_next;
         r_bit <= w_v;
      end
   end

   assign o_bit = r_bit;

endmodule

// File: rtl/dsm_interp_modulator.sv
// ---------------------------------------------------------------------------
// dsm_interp_modulator
// Playback path of the delta-sigma codec: the host loads 16-bit samples as
// MSB/LSB byte pairs into a one-deep staging register, a free-running
// divide-by-64 tick pulls one sample per frame, a 2-stage CIC interpolates
// it by 64 (zero-stuffed, unity DC gain) and dsm_mod2 turns the result into
// a 1-bit bitstream at the clock rate.
// Ports:
//   clk         in   system / bitstream clock
//   rst         in   asynchronous active-high reset
//   in_byte     in   sample byte
//   byte_valid  in   in_byte valid this cycle
//   byte_first  in   with byte_valid: 1 = MSB byte, 0 = LSB byte
//   bit_out     out  modulator bitstream (1 = +FS, 0 = -FS)
//   sample_tick out  one-cycle pulse at each low-rate sample instant
//   sample_req  out  one-cycle pulse the cycle after sample_tick
//   underrun    out  sticky: a tick found no fresh sample
//   overrun     out  sticky: a sample landed on a still-full staging register
// ---------------------------------------------------------------------------
module dsm_interp_modulator
   import dsm_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] in_byte,
   input  logic       byte_valid,
   input  logic       byte_first,
   output logic       bit_out,
   output logic       sample_tick,
   output logic       sample_req,
   output logic       underrun,
   output logic       overrun
);

   localparam logic [OSR_LOG2-1:0] TICK_LAST = '1;

   // Tick generation
   logic [OSR_LOG2-1:0] r_tick_cnt;
   logic                r_req;

   // Byte assembly and staging
   logic [7:0]          r_msb;
   logic                r_msb_pending;
   sample_t             r_staging;
   logic                r_staging_valid;
   logic                r_underrun;
   logic                r_overrun;

   // CIC interpolator
   sample_t             r_x;
   cic_t                r_c1;
   cic_t                r_i1;
   cic_t                r_i2;

   logic                w_tick;
   logic                w_complete;
   sample_t             w_x_sel;
   cic_t                w_c1;
   cic_t                w_c2;
   cic_t                w_int_in;
   cic_t                w_i1_next;
   sample_t             w_u;
   logic                w_bit;

   // ------------------------------------------------------------------
   // Sample-rate tick: same divide-by-64 framing as the decimator.
   // ------------------------------------------------------------------
   assign w_tick = (r_tick_cnt == TICK_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_tick_cnt <= '0;
         r_req      <= 1'b0;
      end else begin
         r_tick_cnt <= r_tick_cnt + OSR_LOG2'(1);
         r_req      <= w_tick;
      end
   end

   // ------------------------------------------------------------------
   // Byte assembly. An LSB only completes a sample when an MSB is pending;
   // a repeated MSB simply replaces the held one.
   // ------------------------------------------------------------------
   assign w_complete = byte_valid & ~byte_first & r_msb_pending;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_msb           <= '0;
         r_msb_pending   <= 1'b0;
         r_staging       <= '0;
         r_staging_valid <= 1'b0;
         r_underrun      <= 1'b0;
         r_overrun       <= 1'b0;
      end else begin
         if (byte_valid & byte_first) begin
            r_msb         <= in_byte;
            r_msb_pending <= 1'b1;
         end else if (w_complete) begin
            r_msb_pending <= 1'b0;
         end

         // NOTE: non-blocking assignment keeps r_staging at its old value
         // for the whole tick cycle, so the tick consumes the previous
         // sample while a sample completing in that same cycle gets staged.
         if (w_complete) begin
            r_staging <= {r_msb, in_byte};
         end

         if (w_tick) begin
            // Consumption empties staging; a same-cycle completion refills
            // it, and that is not an overrun.
            r_staging_valid <= w_complete;
            if (!r_staging_valid) begin
               r_underrun <= 1'b1;
            end
         end else if (w_complete) begin
            r_staging_valid <= 1'b1;
            if (r_staging_valid) begin
               r_overrun <= 1'b1;
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // CIC interpolator. Combs run at the low rate on the tick; the
   // integrators run every clock on the zero-stuffed comb output.
   // Wrap-around arithmetic is intentional: the comb/integrator pairs
   // cancel any wrap exactly.
   // ------------------------------------------------------------------
   assign w_x_sel    = r_staging_valid ? r_staging : r_x;
   assign w_c1       = cic_t'(w_x_sel) - cic_t'(r_x);
   assign w_c2       = w_c1 - r_c1;
   assign w_int_in   = w_tick ? w_c2 : '0;
   assign w_i1_next  = r_i1 + w_int_in;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_x  <= '0;
         r_c1 <= '0;
         r_i1 <= '0;
         r_i2 <= '0;
      end else begin
         if (w_tick) begin
            r_x  <= w_x_sel;
            r_c1 <= w_c1;
         end
         r_i1 <= w_i1_next;
         // Second integrator takes the updated first integrator so a step
         // on x settles at the output exactly 64 cycles after its tick.
         r_i2 <= r_i2 + w_i1_next;
      end
   end

   // Divide out the 64x interpolation gain; the result fits IN_W bits.
   assign w_u = sample_t'(r_i2 >>> OSR_LOG2);

   // ------------------------------------------------------------------
   // Delta-sigma modulator
   // ------------------------------------------------------------------
   dsm_mod2 u_mod2 (
      .clk   (clk),
      .rst   (rst),
      .i_u   (w_u),
      .o_bit (w_bit)
   );

   assign bit_out     = w_bit;
   assign sample_tick = w_tick;
   assign sample_req  = r_req;
   assign underrun    = r_underrun;
   assign overrun     = r_overrun;

endmodule

// File: tb/tb_dsm_interp_modulator.sv
// ---------------------------------------------------------------------------
// tb_dsm_interp_modulator
// Self-checking bench for dsm_interp_modulator. A behavioural model tracks
// the sample pipeline at frame level (staging slot, held sample, held
// per-frame slope of the linear interpolation, integer modulator) and the
// outputs are compared against it every cycle; directed phases add literal
// expectations for reset, tick timing, flags and ones density.
// ---------------------------------------------------------------------------
module tb_dsm_interp_modulator;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] in_byte;
   logic       byte_valid;
   logic       byte_first;
   logic       bit_out;
   logic       sample_tick;
   logic       sample_req;
   logic       underrun;
   logic       overrun;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int ones  = 0;

   always #5 clk = ~clk;

   dsm_interp_modulator dut (
      .clk         (clk),
      .rst         (rst),
      .in_byte     (in_byte),
      .byte_valid  (byte_valid),
      .byte_first  (byte_first),
      .bit_out     (bit_out),
      .sample_tick (sample_tick),
      .sample_req  (sample_req),
      .underrun    (underrun),
      .overrun     (overrun)
   );

   // ------------------------------------------------------------------
   // Reference model
   // ------------------------------------------------------------------
   int         m_cnt, m_stg, m_x, m_xn, m_d, m_acc, m_u, m_fb, m_s1, m_s2;
   logic       m_req, m_bit, m_und, m_ovr, m_pend, m_sv, m_tick, m_comp, m_v;
   logic [7:0] m_msb;

   function automatic int clamp(input int v);
      if (v > 524287)  return 524287;
      if (v < -524287) return -524287;
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_cnt = 0;  m_stg = 0;  m_x = 0;  m_d = 0;  m_acc = 0;
         m_s1 = 0;   m_s2 = 0;   m_req = 0; m_bit = 0; m_und = 0;
         m_ovr = 0;  m_pend = 0; m_sv = 0;  m_msb = 0;
      end else begin
         m_tick = (m_cnt == 63);
         m_comp = byte_valid && !byte_first && m_pend;

         // Modulator works on the interpolated value present before this edge.
         m_u  = m_acc >>> 6;
         m_v  = (m_s2 >= 0);
         m_fb = m_v ? 32768 : -32768;
         m_s1 = clamp(m_s1 + m_u - m_fb);
         m_s2 = clamp(m_s2 + m_s1 - m_fb);
         m_bit = m_v;

         // Interpolator: 64*u ramps linearly from 64*x_prev to 64*x over a frame.
         if (m_tick) begin
            m_xn = m_sv ? m_stg : m_x;
            if (!m_sv) m_und = 1'b1;
            m_d  = m_xn - m_x;
            m_x  = m_xn;
            m_sv = 1'b0;
         end
         m_acc = m_acc + m_d;

         // Host side: staging is emptied by the tick before a new sample lands.
         if (byte_valid && byte_first) begin
            m_msb  = in_byte;
            m_pend = 1'b1;
         end else if (m_comp) begin
            if (m_sv) m_ovr = 1'b1;
            m_stg  = int'($signed({m_msb, in_byte}));
            m_sv   = 1'b1;
            m_pend = 1'b0;
         end

         m_req = m_tick;
         m_cnt = (m_cnt + 1) % 64;
      end
   end

   // ------------------------------------------------------------------
   // Checking
   // ------------------------------------------------------------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input int act, input int lo, input int hi);
      n_chk++;
      if (act < lo || act > hi) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d..%0d (t=%0t)", name, act, lo, hi, $time);
      end
   endtask

   always @(negedge clk) begin
      check("bit_out",     {31'd0, bit_out},     {31'd0, m_bit});
      check("sample_tick", {31'd0, sample_tick}, {31'd0, (m_cnt == 63)});
      check("sample_req",  {31'd0, sample_req},  {31'd0, m_req});
      check("underrun",    {31'd0, underrun},    {31'd0, m_und});
      check("overrun",     {31'd0, overrun},     {31'd0, m_ovr});
   end

   // ------------------------------------------------------------------
   // Stimulus helpers (inputs change 1 time unit after the falling edge)
   // ------------------------------------------------------------------
   task automatic step(input logic bv, input logic bf, input logic [7:0] b);
      byte_valid = bv;
      byte_first = bf;
      in_byte    = b;
      @(negedge clk);
      #1;
      cyc++;
      ones += int'(bit_out);
   endtask

   task automatic do_reset();
      rst        = 1'b1;
      byte_valid = 1'b0;
      byte_first = 1'b0;
      in_byte    = 8'h00;
      repeat (2) begin
         @(negedge clk);
         #1;
      end
      rst = 1'b0;
      cyc = 0;
   endtask

   // One 64-cycle frame starting at a frame boundary: optional sample a at
   // offsets 10/11, optional sample b at 20/21, optional stray LSB at 30.
   task automatic frame(input logic [15:0] a, input logic load_a,
                        input logic [15:0] b, input logic load_b, input logic stray);
      for (int k = 0; k < 64; k++) begin
         case (k)
            10:      step(load_a, 1'b1, a[15:8]);
            11:      step(load_a, 1'b0, a[7:0]);
            20:      step(load_b, 1'b1, b[15:8]);
            21:      step(load_b, 1'b0, b[7:0]);
            30:      step(stray,  1'b0, 8'h55);
            default: step(1'b0, 1'b0, 8'($urandom));
         endcase
      end
   endtask

   task automatic feed_frames(input logic [15:0] val, input int n);
      for (int f = 0; f < n; f++) frame(val, 1'b1, 16'h0000, 1'b0, 1'b0);
   endtask

   initial begin
      #600000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------
   // Directed and random phases
   // ------------------------------------------------------------------
   initial begin
      do_reset();

      // Reset mid-stream with an MSB pending, then a stray LSB after release.
      feed_frames(16'h1234, 3);
      repeat (10) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h77);
      rst = 1'b1;
      #1;
      check("rst_bit_out",     {31'd0, bit_out},     32'd0);
      check("rst_sample_tick", {31'd0, sample_tick}, 32'd0);
      check("rst_sample_req",  {31'd0, sample_req},  32'd0);
      check("rst_underrun",    {31'd0, underrun},    32'd0);
      check("rst_overrun",     {31'd0, overrun},     32'd0);
      do_reset();
      repeat (3) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b0, 8'hA5);
      while (!sample_tick && cyc < 300) step(1'b0, 1'b0, 8'h00);
      check("first_tick_cycle", cyc, 32'd63);
      step(1'b0, 1'b0, 8'h00);
      check("stray_lsb_underrun", {31'd0, underrun},   32'd1);
      check("req_after_tick",     {31'd0, sample_req}, 32'd1);

      // 0x4000: clean first frame with a stray LSB, then +0.5 FS density.
      do_reset();
      frame(16'h4000, 1'b1, 16'h0000, 1'b0, 1'b1);
      check("b_underrun_clean", {31'd0, underrun}, 32'd0);
      check("b_overrun_clean",  {31'd0, overrun},  32'd0);
      feed_frames(16'h4000, 3);
      ones = 0;
      feed_frames(16'h4000, 64);
      check_range("density_p05", ones, 3032, 3112);

      // Skip one frame: underrun sets, held x keeps the density.
      frame(16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0);
      check("skip_underrun", {31'd0, underrun}, 32'd1);
      check("skip_overrun",  {31'd0, overrun},  32'd0);
      ones = 0;
      feed_frames(16'h4000, 64);
      check_range("density_p05_held", ones, 3032, 3112);

      // Two samples in one frame: overrun sets, the newer one plays.
      frame(16'h4000, 1'b1, 16'h2000, 1'b1, 1'b0);
      check("double_overrun", {31'd0, overrun}, 32'd1);
      feed_frames(16'h2000, 4);

      // DC zero.
      do_reset();
      feed_frames(16'h0000, 4);
      ones = 0;
      feed_frames(16'h0000, 64);
      check_range("density_zero", ones, 2028, 2068);
      check("zero_underrun", {31'd0, underrun}, 32'd0);
      check("zero_overrun",  {31'd0, overrun},  32'd0);

      // -0.5 FS.
      do_reset();
      feed_frames(16'hC000, 4);
      ones = 0;
      feed_frames(16'hC000, 64);
      check_range("density_m05", ones, 984, 1064);

      // Sample completing on the tick cycle with staging empty.
      do_reset();
      repeat (62) step(1'b0, 1'b0, 8'h00);
      step(1'b1, 1'b1, 8'h30);
      check("coll_tick_63", {31'd0, sample_tick}, 32'd1);
      step(1'b1, 1'b0, 8'h00);
      check("coll_underrun", {31'd0, underrun},   32'd1);
      check("coll_overrun",  {31'd0, overrun},    32'd0);
      check("coll_req_64",   {31'd0, sample_req}, 32'd1);
      while (cyc < 127) step(1'b0, 1'b0, 8'h00);
      check("coll_tick_127", {31'd0, sample_tick}, 32'd1);
      step(1'b0, 1'b0, 8'h00);
      check("coll_req_128",  {31'd0, sample_req}, 32'd1);
      check("coll_overrun2", {31'd0, overrun},    32'd0);
      while (cyc < 320) step(1'b0, 1'b0, 8'h00);

      // Random byte traffic, any values, any ordering.
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         step(($urandom % 3) == 0, 1'($urandom), 8'($urandom));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
